vga_sync_generator: RTL and testbench

Source side of the raster timing interface. Produces active-low HSYNC and VSYNC, the 3-bit pixel phase `count`, and pixel coordinates for downstream counters such as the horizontal cell counter. The phase `count` reaches 7 every eighth pixel. Sits between the pixel clock enable and the display/character pipeline. All outputs are registered and mutually aligned.

---
 rtl/vga_timing_pkg.sv | 35 +++
 rtl/vga_sync_generator_if.sv | 29 ++
 rtl/sync_axis_counter.sv | 76 +++++++
 rtl/vga_sync_generator.sv | 92 +++++++++
 tb/tb_vga_sync_generator.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared raster timing definitions for the VGA sync generator.
//   phase_t     : position of an axis within its line/frame (active, porches, sync)
//   DEF_*       : default 640x480@60 timing, in pixels (horizontal) or lines (vertical)
//   axis_total  : full period of an axis from its four segment lengths
package vga_timing_pkg;

  typedef enum logic [1:0] {
    ACT   = 2'd0,
    FRONT = 2'd1,
    SYNC  = 2'd2,
    BACK  = 2'd3
  } phase_t;

  localparam int unsigned POS_W = 10;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  function automatic int unsigned axis_total(input int unsigned active,
                                             input int unsigned fp,
                                             input int unsigned sync,
                                             input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  localparam int unsigned DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int unsigned DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_sync_generator_if.sv
// Raster timing bundle driven by vga_sync_generator.
//   HSYNC/VSYNC  : active-low syncs
//   blank_n      : high inside the visible area
//   count        : pixel phase within an 8-pixel cell (x[2:0])
//   x/y          : current pixel position
//   line_start   : high while x==0
//   frame_start  : high while x==0 and y==0
// master = generator side, slave = display/character pipeline side.
interface vga_sync_generator_if;
  import vga_timing_pkg::*;

  logic             HSYNC;
  logic             VSYNC;
  logic             blank_n;
  logic [2:0]       count;
  logic [POS_W-1:0] x;
  logic [POS_W-1:0] y;
  logic             line_start;
  logic             frame_start;

  modport master (
    output HSYNC, VSYNC, blank_n, count, x, y, line_start, frame_start
  );

  modport slave (
    input HSYNC, VSYNC, blank_n, count, x, y, line_start, frame_start
  );

endinterface

// File: rtl/sync_axis_counter.sv
// One raster axis: position counter plus a four-phase FSM (ACT/FRONT/SYNC/BACK).
//   clk, rst_n     : clock, async active-low reset
//   i_advance      : step the axis by one position this cycle
//   o_position     : registered position, 0..TOTAL-1
//   o_phase_nxt    : phase the axis holds after this edge (for aligned registration upstream)
//   o_sync_n       : registered active-low sync, low throughout the SYNC phase
//   o_wrap         : this edge returns the position to 0
module sync_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FP     = DEF_H_FP,
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned BP     = DEF_H_BP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_advance,
  output logic [POS_W-1:0] o_position,
  output phase_t           o_phase_nxt,
  output logic             o_sync_n,
  output logic             o_wrap
);

  localparam int unsigned TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  // Last position of each phase.
  localparam logic [POS_W-1:0] LAST_ACT   = POS_W'(ACTIVE - 1);
  localparam logic [POS_W-1:0] LAST_FRONT = POS_W'(ACTIVE + FP - 1);
  localparam logic [POS_W-1:0] LAST_SYNC  = POS_W'(ACTIVE + FP + SYNC - 1);
  localparam logic [POS_W-1:0] LAST_BACK  = POS_W'(TOTAL - 1);

  logic [POS_W-1:0] r_position;
  logic [POS_W-1:0] w_position_nxt;
  phase_t           r_phase;
  phase_t           w_phase_nxt;
  logic             r_sync_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_position <= '0;
      r_phase    <= vga_timing_pkg::ACT;
      r_sync_n   <= 1'b1;
    end else begin
      r_position <= w_position_nxt;
      r_phase    <= w_phase_nxt;
      r_sync_n   <= (w_phase_nxt != vga_timing_pkg::SYNC);
    end
  end

  always_comb begin
    w_position_nxt = r_position;
    w_phase_nxt    = r_phase;
    if (i_advance) begin
      w_position_nxt = (r_position == LAST_BACK) ? '0 : r_position + 1'b1;
      case (r_phase)
        vga_timing_pkg::ACT:   if (r_position == LAST_ACT)   w_phase_nxt = vga_timing_pkg::FRONT;
        vga_timing_pkg::FRONT: if (r_position == LAST_FRONT) w_phase_nxt = vga_timing_pkg::SYNC;
        vga_timing_pkg::SYNC:  if (r_position == LAST_SYNC)  w_phase_nxt = vga_timing_pkg::BACK;
        vga_timing_pkg::BACK:  if (r_position == LAST_BACK)  w_phase_nxt = vga_timing_pkg::ACT;
        // Corrupted state: restart the axis at the start of the active phase.
        default: begin
          w_phase_nxt    = vga_timing_pkg::ACT;
          w_position_nxt = '0;
        end
      endcase
    end
  end

  assign o_position  = r_position;
  assign o_phase_nxt = w_phase_nxt;
  assign o_sync_n    = r_sync_n;
  // Covers both the natural wrap and the recovery restart.
  assign o_wrap      = i_advance && (w_position_nxt == '0);

endmodule

// File: rtl/vga_sync_generator.sv
// VGA raster timing source: horizontal and vertical axis counters with
// registered, mutually aligned sync, blanking, phase and position outputs.
//   clock     : system clock
//   reset_n   : async active-low reset, forces position (0,0)
//   pixel_en  : pixel-rate enable; nothing changes while low
//   vga       : raster timing bundle (master side)
module vga_sync_generator
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   pixel_en,
  vga_sync_generator_if.master   vga
);

  logic [POS_W-1:0] w_h_pos;
  logic [POS_W-1:0] w_v_pos;
  phase_t           w_h_phase_nxt;
  phase_t           w_v_phase_nxt;
  logic             w_h_sync_n;
  logic             w_v_sync_n;
  logic             w_h_wrap;
  logic             w_v_wrap;

  logic             r_blank_n;
  logic             r_line_start;
  logic             r_frame_start;

  sync_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk         (clock),
    .rst_n       (reset_n),
    .i_advance   (pixel_en),
    .o_position  (w_h_pos),
    .o_phase_nxt (w_h_phase_nxt),
    .o_sync_n    (w_h_sync_n),
    .o_wrap      (w_h_wrap)
  );

  // The vertical axis steps once per line, on the horizontal wrap.
  sync_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk         (clock),
    .rst_n       (reset_n),
    .i_advance   (w_h_wrap),
    .o_position  (w_v_pos),
    .o_phase_nxt (w_v_phase_nxt),
    .o_sync_n    (w_v_sync_n),
    .o_wrap      (w_v_wrap)
  );

  // Flags are registered from the axes' next-state values so they update on
  // the same edge as the positions and syncs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_blank_n     <= 1'b1;
      r_line_start  <= 1'b1;
      r_frame_start <= 1'b1;
    end else if (pixel_en) begin
      r_blank_n     <= (w_h_phase_nxt == ACT) && (w_v_phase_nxt == ACT);
      r_line_start  <= w_h_wrap;
      r_frame_start <= w_h_wrap && w_v_wrap;
    end
  end

  assign vga.HSYNC       = w_h_sync_n;
  assign vga.VSYNC       = w_v_sync_n;
  assign vga.blank_n     = r_blank_n;
  assign vga.count       = w_h_pos[2:0];
  assign vga.x           = w_h_pos;
  assign vga.y           = w_v_pos;
  assign vga.line_start  = r_line_start;
  assign vga.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_generator.sv
module tb_vga_sync_generator;

  localparam int DH_A = 640, DH_F = 16, DH_S = 96, DH_B = 48;
  localparam int DV_A = 480, DV_F = 10, DV_S = 2,  DV_B = 33;
  localparam int DH_T = DH_A + DH_F + DH_S + DH_B;
  localparam int DV_T = DV_A + DV_F + DV_S + DV_B;
  localparam int SH_A = 16, SH_F = 2, SH_S = 4, SH_B = 2;
  localparam int SV_A = 4,  SV_F = 1, SV_S = 1, SV_B = 1;
  localparam int SH_T = SH_A + SH_F + SH_S + SH_B;
  localparam int SV_T = SV_A + SV_F + SV_S + SV_B;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic en_d  = 1'b0;
  logic en_s  = 1'b0;

  always #5 clk = ~clk;

  vga_sync_generator_if vga_d ();
  vga_sync_generator_if vga_s ();

  vga_sync_generator u_def (
    .clock    (clk),
    .reset_n  (rst_n),
    .pixel_en (en_d),
    .vga      (vga_d)
  );

  vga_sync_generator #(
    .H_ACTIVE (SH_A), .H_FP (SH_F), .H_SYNC (SH_S), .H_BP (SH_B),
    .V_ACTIVE (SV_A), .V_FP (SV_F), .V_SYNC (SV_S), .V_BP (SV_B)
  ) u_small (
    .clock    (clk),
    .reset_n  (rst_n),
    .pixel_en (en_s),
    .vga      (vga_s)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: linear pixel index within the frame; position follows by division.
  int pd = 0;
  int ps = 0;
  bit stepped_d = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pd        <= 0;
      ps        <= 0;
      stepped_d <= 1'b0;
    end else begin
      stepped_d <= en_d;
      if (en_d) pd <= (pd + 1) % (DH_T * DV_T);
      if (en_s) ps <= (ps + 1) % (SH_T * SV_T);
    end
  end

  function automatic logic [27:0] exp_out(input int p,
                                          input int ha, input int hf, input int hs, input int hb,
                                          input int va, input int vf, input int vs);
    int ht, x, y;
    logic hsync, vsync, blank;
    ht    = ha + hf + hs + hb;
    x     = p % ht;
    y     = p / ht;
    hsync = !(x >= ha + hf && x < ha + hf + hs);
    vsync = !(y >= va + vf && y < va + vf + vs);
    blank = (x < ha) && (y < va);
    return {hsync, vsync, blank, 3'(x % 8), 10'(x), 10'(y), 1'(x == 0), 1'(x == 0 && y == 0)};
  endfunction

  function automatic logic [27:0] pack_d();
    return {vga_d.HSYNC, vga_d.VSYNC, vga_d.blank_n, vga_d.count, vga_d.x, vga_d.y,
            vga_d.line_start, vga_d.frame_start};
  endfunction

  function automatic logic [27:0] pack_s();
    return {vga_s.HSYNC, vga_s.VSYNC, vga_s.blank_n, vga_s.count, vga_s.x, vga_s.y,
            vga_s.line_start, vga_s.frame_start};
  endfunction

  // Per-cycle comparison plus a downstream cell counter that clears on HSYNC low
  // and counts count==7 inside the visible area.
  int cells = 0;
  always @(negedge clk) begin
    chk("def_outputs", 32'(pack_d()), 32'(exp_out(pd, DH_A, DH_F, DH_S, DH_B, DV_A, DV_F, DV_S)));
    chk("small_outputs", 32'(pack_s()), 32'(exp_out(ps, SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S)));
    if (!rst_n) begin
      cells = 0;
    end else if (stepped_d) begin
      if (!vga_d.HSYNC) cells = 0;
      else if (vga_d.blank_n && vga_d.count == 3'd7) cells++;
      if ((pd % DH_T) == DH_A - 1 && (pd / DH_T) < DV_A)
        chk("rx_cells_per_line", cells, DH_A / 8);
    end
  end

  initial begin
    int hs_low, ls_cnt, vs_low_s, fs_cnt_s, guard;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_x", vga_d.x, 0);
    chk("rst_y", vga_d.y, 0);
    chk("rst_count", vga_d.count, 0);
    chk("rst_hsync", vga_d.HSYNC, 1);
    chk("rst_vsync", vga_d.VSYNC, 1);
    chk("rst_blank_n", vga_d.blank_n, 1);
    chk("rst_line_start", vga_d.line_start, 1);
    chk("rst_frame_start", vga_d.frame_start, 1);

    rst_n = 1'b1;
    en_d  = 1'b1;
    en_s  = 1'b1;
    hs_low = 0; ls_cnt = 0; vs_low_s = 0; fs_cnt_s = 0;
    for (int k = 1; k <= DH_T; k++) begin
      @(negedge clk);
      if (k == 1) chk("first_step_x", vga_d.x, 1);
      if (!vga_d.HSYNC) begin
        hs_low++;
        if (hs_low == 1) chk("hsync_first_x", vga_d.x, 656);
      end
      if (vga_d.line_start) ls_cnt++;
      if (k <= SH_T * SV_T) begin
        if (!vga_s.VSYNC) vs_low_s++;
        if (vga_s.frame_start) fs_cnt_s++;
      end
      if (k == 167) begin
        chk("small_x_167", vga_s.x, 23);
        chk("small_y_167", vga_s.y, 6);
      end
      if (k == 168) begin
        chk("small_frame_start_168", vga_s.frame_start, 1);
        chk("small_pos_168", {vga_s.x, vga_s.y}, 0);
      end
    end
    chk("hsync_low_width", hs_low, 96);
    chk("line_start_count", ls_cnt, 1);
    chk("line_start_at_800", vga_d.line_start, 1);
    chk("x_after_wrap", vga_d.x, 0);
    chk("y_after_wrap", vga_d.y, 1);
    chk("small_vsync_low", vs_low_s, 24);
    chk("small_frame_starts", fs_cnt_s, 1);

    hs_low = 0;
    for (int k = 0; k < 4 * DH_T; k++) begin
      en_d = (k % 4 == 0);
      en_s = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!vga_d.HSYNC) hs_low++;
    end
    chk("hsync_width_1of4", hs_low, 384);

    for (int k = 0; k < 4000; k++) begin
      en_d = 1'($urandom_range(0, 1));
      en_s = 1'($urandom_range(0, 1));
      @(negedge clk);
    end

    en_d  = 1'b1;
    en_s  = 1'b1;
    guard = 0;
    while ((pd % DH_T) != 300 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    chk("reach_x300", vga_d.x, 300);

    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_x", vga_d.x, 0);
    chk("async_rst_y", vga_d.y, 0);
    chk("async_rst_hsync", vga_d.HSYNC, 1);
    chk("async_rst_vsync", vga_d.VSYNC, 1);
    chk("async_rst_blank_n", vga_d.blank_n, 1);
    chk("async_rst_frame_start", vga_d.frame_start, 1);
    chk("async_rst_small_pos", {vga_s.x, vga_s.y}, 0);

    @(negedge clk);
    en_d = 1'b0;
    en_s = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    en_d  = 1'b1;
    en_s  = 1'b1;
    @(negedge clk);
    chk("first_en_after_rst_x", vga_d.x, 1);
    repeat (3 * DH_T) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
